// File: rtl/pit_bus_seq.sv
// pit_bus_seq: turns host commands into timed 8254 counter-0 bus cycles.
// Define PIT_BUS_SEQ_GATE_EN to add the gate0 output that starts the counter after a program.
module pit_bus_seq #(
    parameter int STB_CYC = 2,
    parameter int GAP_CYC = 1
) (
    input  logic        clk,
    input  logic        RST_N,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic        cmd_bcd,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_count,
    output logic [7:0]  rsp_status,
    output logic        CS_N,
    output logic [1:0]  a,
    output logic [7:0]  id,
    input  logic [7:0]  od,
    output logic        IOR_N,
    output logic        IOW_N
`ifdef PIT_BUS_SEQ_GATE_EN
    ,
    output logic        gate0
`endif
);

    typedef enum logic [1:0] {
        OP_PROG  = 2'b00,
        OP_LATCH = 2'b01,
        OP_RDBK  = 2'b10,
        OP_RSVD  = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_SETUP, S_STROBE, S_HOLD, S_GAP, S_DONE
    } state_t;

    state_t      state;
    op_t         r_op;
    logic [1:0]  r_rw;
    logic [7:0]  r_lsb, r_msb, r_ctl;
    logic        r_err;
    logic [2:0]  nacc, idx;
    logic        cur_wr;
    logic [7:0]  b0, b1, st_b;
    logic [15:0] cnt;
    logic        cfg_ok;
    logic [1:0]  cfg_rw;

    function automatic logic nib_bad(input logic [7:0] b);
        return (b[7:4] > 4'd9) || (b[3:0] > 4'd9);
    endfunction

    logic [2:0] eff_mode;
    logic       legal;

    always_comb begin
        eff_mode = (cmd_mode[2:1] == 2'b11) ? {1'b0, cmd_mode[1:0]} : cmd_mode;
        legal    = 1'b1;
        case (cmd_op)
            OP_PROG: begin
                if (cmd_rw == 2'b00)
                    legal = 1'b0;
                if (cmd_bcd && ((cmd_rw[0] && nib_bad(cmd_count[7:0])) ||
                                (cmd_rw[1] && nib_bad(cmd_count[15:8]))))
                    legal = 1'b0;
                if (eff_mode == 3'd3 && ((cmd_rw == 2'b01 && cmd_count[7:0] == 8'h01) ||
                                         (cmd_rw == 2'b11 && cmd_count == 16'h0001)))
                    legal = 1'b0;
            end
            OP_LATCH, OP_RDBK: legal = cfg_ok;
            default:           legal = 1'b0;
        endcase
    end

    // Access 0 is always the control-word write; program follows with count writes, reads with od reads.
    logic [2:0] nidx;
    logic       n_wr;
    logic [1:0] n_a;
    logic [7:0] n_d;

    always_comb begin
        nidx = (state == S_CHECK) ? 3'd0 : idx + 3'd1;
        n_wr = (nidx == 3'd0) || (r_op == OP_PROG);
        n_a  = (nidx == 3'd0) ? 2'b11 : 2'b00;
        n_d  = 8'h00;
        if (nidx == 3'd0)
            n_d = r_ctl;
        else if (r_op == OP_PROG)
            n_d = (nidx == 3'd1 && r_rw != 2'b10) ? r_lsb : r_msb;
    end

    always_ff @(posedge clk) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_count  <= '0;
            rsp_status <= '0;
            CS_N       <= 1'b1;
            a          <= '0;
            id         <= '0;
            IOR_N      <= 1'b1;
            IOW_N      <= 1'b1;
            cfg_ok     <= 1'b0;
            cfg_rw     <= '0;
            r_op       <= OP_PROG;
            r_rw       <= '0;
            r_lsb      <= '0;
            r_msb      <= '0;
            r_ctl      <= '0;
            r_err      <= 1'b0;
            nacc       <= '0;
            idx        <= '0;
            cur_wr     <= 1'b0;
            b0         <= '0;
            b1         <= '0;
            st_b       <= '0;
            cnt        <= '0;
`ifdef PIT_BUS_SEQ_GATE_EN
            gate0      <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: if (cmd_valid && cmd_ready) begin
                    cmd_ready <= 1'b0;
                    state     <= S_CHECK;
                    r_op      <= op_t'(cmd_op);
                    r_err     <= !legal;
                    r_lsb     <= cmd_count[7:0];
                    r_msb     <= cmd_count[15:8];
                    if (cmd_op == OP_PROG) begin
                        r_rw  <= cmd_rw;
                        r_ctl <= {2'b00, cmd_rw, cmd_mode, cmd_bcd};
                        nacc  <= (cmd_rw == 2'b11) ? 3'd3 : 3'd2;
                    end else if (cmd_op == OP_LATCH) begin
                        r_rw  <= cfg_rw;
                        r_ctl <= 8'h00;
                        nacc  <= (cfg_rw == 2'b11) ? 3'd3 : 3'd2;
                    end else begin
                        r_rw  <= cfg_rw;
                        r_ctl <= 8'hC2;
                        nacc  <= (cfg_rw == 2'b11) ? 3'd4 : 3'd3;
                    end
`ifdef PIT_BUS_SEQ_GATE_EN
                    if (cmd_op == OP_PROG && legal)
                        gate0 <= 1'b0;
`endif
                end
                S_CHECK: begin
                    if (r_err) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        state  <= S_SETUP;
                        idx    <= nidx;
                        cur_wr <= n_wr;
                        CS_N   <= 1'b0;
                        a      <= n_a;
                        id     <= n_d;
                    end
                end
                S_SETUP: begin
                    state <= S_STROBE;
                    cnt   <= '0;
                    if (cur_wr)
                        IOW_N <= 1'b0;
                    else
                        IOR_N <= 1'b0;
                end
                S_STROBE: begin
                    if (cnt == 16'(STB_CYC - 1)) begin
                        state <= S_HOLD;
                        IOW_N <= 1'b1;
                        IOR_N <= 1'b1;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    state <= S_GAP;
                    CS_N  <= 1'b1;
                    cnt   <= '0;
                    if (!cur_wr) begin
                        if (r_op == OP_RDBK && idx == 3'd1)
                            st_b <= od;
                        else if ((r_op == OP_RDBK && idx == 3'd3) || (r_op == OP_LATCH && idx == 3'd2))
                            b1 <= od;
                        else
                            b0 <= od;
                    end
                end
                S_GAP: begin
                    if (cnt == 16'(GAP_CYC - 1)) begin
                        if (nidx == nacc) begin
                            state     <= S_DONE;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            if (r_op == OP_PROG) begin
                                cfg_ok <= 1'b1;
                                cfg_rw <= r_rw;
`ifdef PIT_BUS_SEQ_GATE_EN
                                gate0  <= 1'b1;
`endif
                            end else begin
                                case (r_rw)
                                    2'b01:   rsp_count <= {8'h00, b0};
                                    2'b10:   rsp_count <= {b0, 8'h00};
                                    default: rsp_count <= {b1, b0};
                                endcase
                                if (r_op == OP_RDBK)
                                    rsp_status <= st_b;
                            end
                        end else begin
                            state  <= S_SETUP;
                            idx    <= nidx;
                            cur_wr <= n_wr;
                            CS_N   <= 1'b0;
                            a      <= n_a;
                            id     <= n_d;
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    rsp_valid <= 1'b0;
                    rsp_err   <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
